jzjpcc_hazard_scoreboard: RTL and testbench

Parametrised hazard/forwarding unit for the pipelined core, supporting non-blocking loads with variable memory latency. Tracks up to MAX_OUTSTANDING in-flight loads in an in-order tag FIFO plus a per-register busy scoreboard. Generates decode/execute bypass selects and values from memory, writeback and load-return, plus fetch/decode stalls and decode/execute flushes. Sits beside decode/execute, fed by every stage and the data-memory port.

---
 rtl/jzjpcc_pkg.sv | 15 +
 rtl/jzjpcc_load_tag_fifo.sv | 54 +++++
 rtl/jzjpcc_hazard_scoreboard.sv | 185 ++++++++++++++++++
 tb/tb_jzjpcc_hazard_scoreboard.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jzjpcc_pkg.sv
// Shared types for the jzjpcc hazard/forwarding logic: register address type
// and the bypass-source encoding used by the forwarding muxes.
package jzjpcc_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] regAddr_t;

  typedef enum logic [1:0] {
    NONE,
    MEMORY,
    WRITEBACK,
    LOADRET
  } bypassSrc_e;
endpackage

// File: rtl/jzjpcc_load_tag_fifo.sv
// In-order tag FIFO of destination registers for outstanding loads.
// Rejected pushes/pops leave the pointers untouched; the caller flags them.
module jzjpcc_load_tag_fifo
  import jzjpcc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_tag,
  input  logic                  pop,
  output logic [REG_ADDR_W-1:0] head,
  output logic [CNT_W-1:0]      count,
  output logic                  push_ok,
  output logic                  pop_ok
);
  logic [REG_ADDR_W-1:0] tags [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  empty;
  logic                  full;

  // A push into a full FIFO is still accepted when the head leaves the same cycle.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_W'(DEPTH));
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    head    = empty ? '0 : tags[rd_ptr];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) tags[wr_ptr] <= push_tag;
  end
endmodule

// File: rtl/jzjpcc_hazard_scoreboard.sv
// Hazard, stall/flush and bypass unit with a non-blocking load scoreboard.
// Optional performance counters are built when JZJPCC_HAZARD_PERF_EN is defined.
module jzjpcc_hazard_scoreboard
  import jzjpcc_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int NUM_SRC         = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STALL_TIMEOUT   = 1023,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_SRC*5-1:0]    rsAddr_decode,
  input  logic [NUM_SRC*5-1:0]    rsAddr_execute,
  input  logic [4:0]              rdAddr_decode,
  input  logic                    rdWriteEnable_decode,
  input  logic [4:0]              rdAddr_execute,
  input  logic [4:0]              rdAddr_memory,
  input  logic [4:0]              rdAddr_writeback,
  input  logic                    rdWriteEnable_execute,
  input  logic                    rdWriteEnable_memory,
  input  logic                    rdWriteEnable_writeback,
  input  logic                    isLoad_execute,
  input  logic                    pcCTWriteEnable,
  input  logic                    loadIssue,
  input  logic [4:0]              loadIssueRd,
  input  logic                    loadDone,
  input  logic [XLEN-1:0]         loadDoneData,
  input  logic [XLEN-1:0]         aluResult_memory,
  input  logic [XLEN-1:0]         rd_writebackEnd,
  output logic                    stall_fetch,
  output logic                    stall_decode,
  output logic                    flush_decode,
  output logic                    flush_execute,
  output logic                    stall_memory,
  output logic [4:0]              loadDoneRd,
  output logic [NUM_SRC-1:0]      bypassSel_decode,
  output logic [NUM_SRC-1:0]      bypassSel_execute,
  output logic [NUM_SRC*XLEN-1:0] bypassValue_decode,
  output logic [NUM_SRC*XLEN-1:0] bypassValue_execute,
  output logic                    watchdogError,
  output logic                    protocolError
`ifdef JZJPCC_HAZARD_PERF_EN
  ,
  output logic [31:0]             perfStallCycles,
  output logic [31:0]             perfFlushCount,
  output logic [CNT_W-1:0]        perfLoadPeak
`endif
);
  localparam int WD_W = $clog2(STALL_TIMEOUT + 1);

  logic [CNT_W-1:0]    count;
  logic                push_ok;
  logic                pop_ok;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [WD_W-1:0]     stall_cnt;
  logic [WD_W-1:0]     stall_cnt_next;
  logic                stall;
  logic                src_hazard;
  logic                waw_hazard;
  logic                ctrl_hazard;
  logic [4:0]          rs;

  function automatic logic [WD_W-1:0] sat_inc_wd(input logic [WD_W-1:0] v);
    return (v == WD_W'(STALL_TIMEOUT)) ? v : v + 1'b1;
  endfunction

  function automatic bypassSrc_e pick_src(input logic [4:0] src_rs, input logic fwd_wb);
    bypassSrc_e src;
    src = NONE;
    if (src_rs != '0) begin
      if (rdWriteEnable_memory && rdAddr_memory == src_rs)
        src = MEMORY;
      else if (fwd_wb && rdWriteEnable_writeback && rdAddr_writeback == src_rs)
        src = WRITEBACK;
      else if (loadDone && loadDoneRd == src_rs)
        src = LOADRET;
    end
    return src;
  endfunction

  function automatic logic [XLEN-1:0] src_value(input bypassSrc_e src);
    case (src)
      MEMORY:    return aluResult_memory;
      WRITEBACK: return rd_writebackEnd;
      LOADRET:   return loadDoneData;
      default:   return '0;
    endcase
  endfunction

  jzjpcc_load_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (loadIssue),
    .push_tag (loadIssueRd),
    .pop      (loadDone),
    .head     (loadDoneRd),
    .count    (count),
    .push_ok  (push_ok),
    .pop_ok   (pop_ok)
  );

  assign stall_memory = (count == CNT_W'(MAX_OUTSTANDING));

  // Set-after-clear ordering makes a same-cycle re-issue of the popped register win.
  always_comb begin
    busy_next = busy;
    if (pop_ok) busy_next[loadDoneRd] = 1'b0;
    if (push_ok && loadIssueRd != '0) busy_next[loadIssueRd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    src_hazard  = 1'b0;
    ctrl_hazard = 1'b0;
    rs          = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs = rsAddr_decode[i*5 +: 5];
      if (rs != '0) begin
        if (busy[rs] && !(loadDone && loadDoneRd == rs)) src_hazard = 1'b1;
        if (isLoad_execute && rdWriteEnable_execute && rs == rdAddr_execute) src_hazard = 1'b1;
        if (pcCTWriteEnable && ((rdWriteEnable_execute && rs == rdAddr_execute) || busy[rs]))
          ctrl_hazard = 1'b1;
      end
    end
    waw_hazard    = rdWriteEnable_decode && rdAddr_decode != '0 && busy[rdAddr_decode];
    stall         = src_hazard || waw_hazard || ctrl_hazard;
    stall_fetch   = stall;
    stall_decode  = stall;
    flush_execute = stall;
    flush_decode  = pcCTWriteEnable && !stall;
  end

  // Decode does not take writeback: the register file writes on the falling edge.
  always_comb begin
    bypassSel_decode    = '0;
    bypassSel_execute   = '0;
    bypassValue_decode  = '0;
    bypassValue_execute = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      bypassSel_decode[i]                 = (pick_src(rsAddr_decode[i*5 +: 5], 1'b0) != NONE);
      bypassValue_decode[i*XLEN +: XLEN]  = src_value(pick_src(rsAddr_decode[i*5 +: 5], 1'b0));
      bypassSel_execute[i]                = (pick_src(rsAddr_execute[i*5 +: 5], 1'b1) != NONE);
      bypassValue_execute[i*XLEN +: XLEN] = src_value(pick_src(rsAddr_execute[i*5 +: 5], 1'b1));
    end
  end

  assign stall_cnt_next = stall ? sat_inc_wd(stall_cnt) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy          <= '0;
      stall_cnt     <= '0;
      watchdogError <= 1'b0;
      protocolError <= 1'b0;
    end else begin
      busy      <= busy_next;
      stall_cnt <= stall_cnt_next;
      if (stall_cnt_next == WD_W'(STALL_TIMEOUT)) watchdogError <= 1'b1;
      if ((loadIssue && !push_ok) || (loadDone && !pop_ok)) protocolError <= 1'b1;
    end
  end

`ifdef JZJPCC_HAZARD_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perfStallCycles <= '0;
      perfFlushCount  <= '0;
      perfLoadPeak    <= '0;
    end else begin
      if (stall)        perfStallCycles <= sat_inc32(perfStallCycles);
      if (flush_decode) perfFlushCount  <= sat_inc32(perfFlushCount);
      if (count > perfLoadPeak) perfLoadPeak <= count;
    end
  end
`endif
endmodule

// File: tb/tb_jzjpcc_hazard_scoreboard.sv
// Directed bench for jzjpcc_hazard_scoreboard: combinational vector table plus
// hand-written load/scoreboard, FIFO-capacity, watchdog and reset sequences.
module tb_jzjpcc_hazard_scoreboard;
  localparam int XLEN = 32;
  localparam int NSRC = 2;
  localparam int TMO  = 16;

  logic clock = 1'b0;
  logic reset;
  logic [NSRC*5-1:0] rsAddr_decode, rsAddr_execute;
  logic [4:0] rdAddr_decode, rdAddr_execute, rdAddr_memory, rdAddr_writeback;
  logic rdWriteEnable_decode, rdWriteEnable_execute, rdWriteEnable_memory, rdWriteEnable_writeback;
  logic isLoad_execute, pcCTWriteEnable, loadIssue, loadDone;
  logic [4:0] loadIssueRd;
  logic [XLEN-1:0] loadDoneData, aluResult_memory, rd_writebackEnd;
  logic stall_fetch, stall_decode, flush_decode, flush_execute, stall_memory;
  logic [4:0] loadDoneRd;
  logic [NSRC-1:0] bypassSel_decode, bypassSel_execute;
  logic [NSRC*XLEN-1:0] bypassValue_decode, bypassValue_execute;
  logic watchdogError, protocolError;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  jzjpcc_hazard_scoreboard #(
    .XLEN(XLEN), .NUM_SRC(NSRC), .MAX_OUTSTANDING(4), .STALL_TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .rsAddr_decode(rsAddr_decode), .rsAddr_execute(rsAddr_execute),
    .rdAddr_decode(rdAddr_decode), .rdWriteEnable_decode(rdWriteEnable_decode),
    .rdAddr_execute(rdAddr_execute), .rdAddr_memory(rdAddr_memory),
    .rdAddr_writeback(rdAddr_writeback),
    .rdWriteEnable_execute(rdWriteEnable_execute), .rdWriteEnable_memory(rdWriteEnable_memory),
    .rdWriteEnable_writeback(rdWriteEnable_writeback),
    .isLoad_execute(isLoad_execute), .pcCTWriteEnable(pcCTWriteEnable),
    .loadIssue(loadIssue), .loadIssueRd(loadIssueRd),
    .loadDone(loadDone), .loadDoneData(loadDoneData),
    .aluResult_memory(aluResult_memory), .rd_writebackEnd(rd_writebackEnd),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .flush_decode(flush_decode), .flush_execute(flush_execute),
    .stall_memory(stall_memory), .loadDoneRd(loadDoneRd),
    .bypassSel_decode(bypassSel_decode), .bypassSel_execute(bypassSel_execute),
    .bypassValue_decode(bypassValue_decode), .bypassValue_execute(bypassValue_execute),
    .watchdogError(watchdogError), .protocolError(protocolError)
  );

  typedef struct {
    logic [9:0]  rsd, rse;
    logic [4:0]  rde;
    logic        we_e, isld;
    logic [4:0]  rdm;
    logic        we_m;
    logic [4:0]  rdw;
    logic        we_w, pcct;
    logic        stall, flush_d;
    logic [1:0]  bsel_e;
    logic [63:0] bval_e;
    logic [1:0]  bsel_d;
    logic [63:0] bval_d;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rsAddr_decode = '0; rsAddr_execute = '0;
    rdAddr_decode = '0; rdAddr_execute = '0; rdAddr_memory = '0; rdAddr_writeback = '0;
    rdWriteEnable_decode = 0; rdWriteEnable_execute = 0;
    rdWriteEnable_memory = 0; rdWriteEnable_writeback = 0;
    isLoad_execute = 0; pcCTWriteEnable = 0;
    loadIssue = 0; loadIssueRd = '0; loadDone = 0; loadDoneData = '0;
    aluResult_memory = 32'h11; rd_writebackEnd = 32'h22;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] ctl_bits();
    return {stall_fetch, stall_decode, flush_execute, flush_decode};
  endfunction

  function automatic logic [3:0] ctl_exp(input logic s, input logic f);
    return {s, s, s, f};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    next_cycle();
  endtask

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{10'd0, 10'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0,
                 0, 0, 2'b00, 64'h0, 2'b00, 64'h0};
    vecs[1]  = '{10'd0, {5'd9, 5'd0}, 5'd0, 0, 0, 5'd9, 1, 5'd9, 1, 0,
                 0, 0, 2'b10, {32'h11, 32'h0}, 2'b00, 64'h0};
    vecs[2]  = '{10'd0, {5'd9, 5'd0}, 5'd0, 0, 0, 5'd9, 0, 5'd9, 1, 0,
                 0, 0, 2'b10, {32'h22, 32'h0}, 2'b00, 64'h0};
    vecs[3]  = '{10'd0, {5'd9, 5'd9}, 5'd0, 0, 0, 5'd9, 1, 5'd9, 1, 0,
                 0, 0, 2'b11, {32'h11, 32'h11}, 2'b00, 64'h0};
    vecs[4]  = '{10'd0, 10'd0, 5'd0, 0, 0, 5'd0, 1, 5'd0, 1, 0,
                 0, 0, 2'b00, 64'h0, 2'b00, 64'h0};
    vecs[5]  = '{{5'd4, 5'd3}, 10'd0, 5'd0, 0, 0, 5'd3, 1, 5'd4, 1, 0,
                 0, 0, 2'b00, 64'h0, 2'b01, {32'h0, 32'h11}};
    vecs[6]  = '{10'd0, 10'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 1,
                 0, 1, 2'b00, 64'h0, 2'b00, 64'h0};
    vecs[7]  = '{{5'd0, 5'd6}, 10'd0, 5'd6, 1, 0, 5'd0, 0, 5'd0, 0, 1,
                 1, 0, 2'b00, 64'h0, 2'b00, 64'h0};
    vecs[8]  = '{{5'd6, 5'd0}, 10'd0, 5'd6, 1, 1, 5'd0, 0, 5'd0, 0, 0,
                 1, 0, 2'b00, 64'h0, 2'b00, 64'h0};
    vecs[9]  = '{{5'd6, 5'd0}, 10'd0, 5'd6, 0, 1, 5'd0, 0, 5'd0, 0, 0,
                 0, 0, 2'b00, 64'h0, 2'b00, 64'h0};
    vecs[10] = '{10'd0, 10'd0, 5'd0, 1, 1, 5'd0, 0, 5'd0, 0, 0,
                 0, 0, 2'b00, 64'h0, 2'b00, 64'h0};
    vecs[11] = '{{5'd5, 5'd0}, {5'd5, 5'd5}, 5'd5, 0, 0, 5'd6, 1, 5'd5, 1, 1,
                 0, 1, 2'b11, {32'h22, 32'h22}, 2'b00, 64'h0};

    clear_inputs();
    reset = 1'b1;
    #12;
    // Reset state, with reset still asserted
    chk("rst_ctl", 64'(ctl_bits()), 64'h0);
    chk("rst_stall_mem", 64'(stall_memory), 64'h0);
    chk("rst_bsel", 64'({bypassSel_decode, bypassSel_execute}), 64'h0);
    chk("rst_flags", 64'({watchdogError, protocolError}), 64'h0);
    chk("rst_donerd", 64'(loadDoneRd), 64'h0);
    reset = 1'b0;
    next_cycle();

    for (int i = 0; i < 12; i++) begin
      clear_inputs();
      rsAddr_decode = vecs[i].rsd;       rsAddr_execute = vecs[i].rse;
      rdAddr_execute = vecs[i].rde;      rdWriteEnable_execute = vecs[i].we_e;
      isLoad_execute = vecs[i].isld;
      rdAddr_memory = vecs[i].rdm;       rdWriteEnable_memory = vecs[i].we_m;
      rdAddr_writeback = vecs[i].rdw;    rdWriteEnable_writeback = vecs[i].we_w;
      pcCTWriteEnable = vecs[i].pcct;
      #3;
      chk($sformatf("vec%0d_ctl", i), 64'(ctl_bits()), 64'(ctl_exp(vecs[i].stall, vecs[i].flush_d)));
      chk($sformatf("vec%0d_bsel_e", i), 64'(bypassSel_execute), 64'(vecs[i].bsel_e));
      chk($sformatf("vec%0d_bval_e", i), bypassValue_execute, vecs[i].bval_e);
      chk($sformatf("vec%0d_bsel_d", i), 64'(bypassSel_decode), 64'(vecs[i].bsel_d));
      chk($sformatf("vec%0d_bval_d", i), bypassValue_decode, vecs[i].bval_d);
      next_cycle();
    end
    clear_inputs();
    do_reset();

    // Load-use through the scoreboard, released by the returning load
    loadIssue = 1; loadIssueRd = 5'd5;
    next_cycle();
    loadIssue = 0;
    rsAddr_decode = {5'd0, 5'd5};
    #3;
    chk("ld_stall_1", 64'(ctl_bits()), 64'(ctl_exp(1, 0)));
    next_cycle();
    chk("ld_stall_2", 64'(ctl_bits()), 64'(ctl_exp(1, 0)));
    rsAddr_decode = '0; rdAddr_decode = 5'd5; rdWriteEnable_decode = 1;
    #3;
    chk("waw_stall", 64'(stall_decode), 64'h1);
    rdWriteEnable_decode = 0; rdAddr_decode = '0;
    pcCTWriteEnable = 1; rsAddr_decode = {5'd5, 5'd0};
    #1;
    chk("ctl_busy_stall", 64'(ctl_bits()), 64'(ctl_exp(1, 0)));
    pcCTWriteEnable = 0; rsAddr_decode = {5'd0, 5'd5};
    loadDone = 1; loadDoneData = 32'hDEAD;
    #1;
    chk("ld_done_rd", 64'(loadDoneRd), 64'd5);
    chk("ld_bsel_d", 64'(bypassSel_decode), 64'h1);
    chk("ld_bval_d", 64'(bypassValue_decode[31:0]), 64'hDEAD);
    chk("ld_done_nostall", 64'(ctl_bits()), 64'h0);
    next_cycle();
    loadDone = 0;
    #1;
    chk("ld_after_nostall", 64'(stall_decode), 64'h0);
    clear_inputs();

    // Fill the tracker, overflow it, then drain in issue order
    for (int r = 1; r <= 4; r++) begin
      loadIssue = 1; loadIssueRd = 5'(r);
      next_cycle();
    end
    loadIssue = 0;
    chk("full_stall_mem", 64'(stall_memory), 64'h1);
    chk("full_no_perr", 64'(protocolError), 64'h0);
    loadIssue = 1; loadIssueRd = 5'd9;
    next_cycle();
    loadIssue = 0;
    chk("ovf_perr", 64'(protocolError), 64'h1);
    chk("ovf_still_full", 64'(stall_memory), 64'h1);
    for (int r = 1; r <= 4; r++) begin
      loadDone = 1;
      #1;
      chk($sformatf("drain_rd%0d", r), 64'(loadDoneRd), 64'(r));
      next_cycle();
    end
    loadDone = 0;
    chk("drain_empty", 64'(stall_memory), 64'h0);
    chk("drain_rd_zero", 64'(loadDoneRd), 64'h0);
    clear_inputs();
    do_reset();
    chk("perr_cleared", 64'(protocolError), 64'h0);

    // Re-issue of the register being returned keeps it busy
    loadIssue = 1; loadIssueRd = 5'd7;
    next_cycle();
    loadDone = 1;
    #1;
    chk("reissue_head", 64'(loadDoneRd), 64'd7);
    next_cycle();
    loadIssue = 0; loadDone = 0;
    rsAddr_decode = {5'd0, 5'd7};
    #1;
    chk("reissue_busy", 64'(stall_decode), 64'h1);
    loadDone = 1; loadDoneData = 32'h77;
    #1;
    chk("reissue_ret_ok", 64'(stall_decode), 64'h0);
    next_cycle();
    loadDone = 0;
    #1;
    chk("reissue_clear", 64'(stall_decode), 64'h0);
    chk("reissue_no_perr", 64'(protocolError), 64'h0);
    clear_inputs();
    do_reset();

    // Watchdog: sets on the TMO-th consecutive stall cycle
    loadIssue = 1; loadIssueRd = 5'd10;
    next_cycle();
    loadIssue = 0;
    rsAddr_decode = {5'd10, 5'd0};
    for (int k = 0; k < TMO - 1; k++) next_cycle();
    chk("wd_before", 64'(watchdogError), 64'h0);
    next_cycle();
    chk("wd_set", 64'(watchdogError), 64'h1);
    next_cycle();
    chk("wd_sticky", 64'(watchdogError), 64'h1);

    // Reset in the middle of the stall discards the outstanding load
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_flags", 64'({watchdogError, protocolError}), 64'h0);
    chk("mid_rst_ctl", 64'(ctl_bits()), 64'h0);
    reset = 1'b0;
    next_cycle();
    chk("post_rst_nostall", 64'(stall_decode), 64'h0);
    loadDone = 1;
    #1;
    chk("late_done_rd", 64'(loadDoneRd), 64'h0);
    next_cycle();
    loadDone = 0;
    chk("late_done_perr", 64'(protocolError), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
